uart_fifo: RTL and testbench

UART_FIFO -- requirements
Module: uart_fifo

---
 rtl/uart_fifo.sv | 80 ++++++++
 tb/tb_uart_fifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO between UART receiver and transmitter.
// Write-to-read latency 1 cycle; ready/valid decoded from registered count only.
module uart_fifo #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_clr,
   input  logic                     i_wr_valid,
   input  logic [DATA_W-1:0]        i_wr_data,
   output logic                     o_wr_ready,
   output logic                     o_rd_valid,
   output logic [DATA_W-1:0]        o_rd_data,
   input  logic                     i_rd_ready,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_almost_full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wptr_q, wptr_d;
   logic [AW-1:0]     rptr_q, rptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              af_q, af_d;
   logic              wr_en, rd_en;

   assign o_wr_ready    = (cnt_q != FULL_C);
   assign o_rd_valid    = (cnt_q != '0);
   assign wr_en         = i_wr_valid && o_wr_ready;
   assign rd_en         = o_rd_valid && i_rd_ready;
   assign o_count       = cnt_q;
   assign o_almost_full = af_q;
   // Gating keeps the head at zero while empty, which also yields the reset value.
   assign o_rd_data     = o_rd_valid ? mem_q[rptr_q] : '0;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (i_clr) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (wr_en) wptr_d = wptr_q + 1'b1;
         if (rd_en) rptr_d = rptr_q + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
      af_d = (cnt_d >= AF_C);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         af_q   <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         af_q   <= af_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !i_clr) mem_q[wptr_q] <= i_wr_data;
   end

endmodule

// File: tb/tb_uart_fifo.sv
// Directed-vector bench for uart_fifo (DATA_W=8, DEPTH=16, AF_LEVEL=14).
module tb_uart_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_clr, i_wr_valid, i_rd_ready;
   logic [7:0] i_wr_data;
   logic       o_wr_ready, o_rd_valid, o_almost_full;
   logic [7:0] o_rd_data;
   logic [4:0] o_count;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   uart_fifo #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14)) dut (
      .clk(clk), .rst(rst), .i_clr(i_clr),
      .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready),
      .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .i_rd_ready(i_rd_ready),
      .o_count(o_count), .o_almost_full(o_almost_full)
   );

   typedef struct {
      logic       clr;
      logic       wv;
      logic [7:0] wd;
      logic       rr;
      logic [4:0] e_cnt;
      logic       e_rv;
      logic [7:0] e_rd;
      logic       e_wrdy;
      logic       e_af;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic clr, input logic wv, input logic [7:0] wd, input logic rr);
      i_clr      = clr;
      i_wr_valid = wv;
      i_wr_data  = wd;
      i_rd_ready = rr;
   endtask

   // Advance one edge and settle past it.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   int         q[$];
   int         sent, recv, mcnt;
   logic       wacc, racc;
   logic [4:0] max_cnt;

   initial begin
      vecs[0] = '{1'b0, 1'b1, 8'h11, 1'b0, 5'd1, 1'b1, 8'h11, 1'b1, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 8'h22, 1'b0, 5'd2, 1'b1, 8'h11, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 8'h33, 1'b0, 5'd3, 1'b1, 8'h11, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd2, 1'b1, 8'h22, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd1, 1'b1, 8'h33, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00, 1'b1, 1'b0};
      // Write and read together while empty: only the write lands.
      vecs[6] = '{1'b0, 1'b1, 8'h44, 1'b1, 5'd1, 1'b1, 8'h44, 1'b1, 1'b0};
      vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00, 1'b1, 1'b0};

      rst = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      #12;
      chk("rst_count", 32'(o_count), 32'd0);
      chk("rst_rv", 32'(o_rd_valid), 32'd0);
      chk("rst_wrdy", 32'(o_wr_ready), 32'd1);
      chk("rst_af", 32'(o_almost_full), 32'd0);
      chk("rst_rdata", 32'(o_rd_data), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Basic order and empty corner
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].clr, vecs[i].wv, vecs[i].wd, vecs[i].rr);
         cyc();
         chk("vec_count", 32'(o_count), 32'(vecs[i].e_cnt));
         chk("vec_rv", 32'(o_rd_valid), 32'(vecs[i].e_rv));
         chk("vec_wrdy", 32'(o_wr_ready), 32'(vecs[i].e_wrdy));
         chk("vec_af", 32'(o_almost_full), 32'(vecs[i].e_af));
         if (vecs[i].e_rv) chk("vec_rdata", 32'(o_rd_data), 32'(vecs[i].e_rd));
      end

      // Fill to full, almost-full from 14
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b1, 8'(i), 1'b0);
         cyc();
         chk("fill_count", 32'(o_count), 32'(i + 1));
         chk("fill_af", 32'(o_almost_full), 32'((i + 1) >= 14));
         chk("fill_head", 32'(o_rd_data), 32'h00);
      end
      chk("full_wrdy", 32'(o_wr_ready), 32'd0);
      drive(1'b0, 1'b1, 8'hAA, 1'b0);
      cyc();
      chk("full_reject_count", 32'(o_count), 32'd16);
      chk("full_hold_head", 32'(o_rd_data), 32'h00);
      // Read and write together at full: read only
      drive(1'b0, 1'b1, 8'hAA, 1'b1);
      cyc();
      chk("full_rw_count", 32'(o_count), 32'd15);
      chk("full_rw_wrdy", 32'(o_wr_ready), 32'd1);
      chk("full_rw_af", 32'(o_almost_full), 32'd1);
      for (int i = 1; i < 16; i++) begin
         chk("drain_data", 32'(o_rd_data), 32'(i));
         drive(1'b0, 1'b0, 8'h00, 1'b1);
         cyc();
      end
      chk("drain_count", 32'(o_count), 32'd0);
      chk("drain_rv", 32'(o_rd_valid), 32'd0);

      // Simultaneous write/read at count 5
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 8'(8'h50 + i), 1'b0);
         cyc();
      end
      drive(1'b0, 1'b1, 8'h55, 1'b1);
      cyc();
      chk("mid_rw_count", 32'(o_count), 32'd5);
      chk("mid_rw_head", 32'(o_rd_data), 32'h51);
      for (int i = 0; i < 5; i++) begin
         chk("mid_drain", 32'(o_rd_data), 32'(8'h51 + i));
         drive(1'b0, 1'b0, 8'h00, 1'b1);
         cyc();
      end
      chk("mid_empty", 32'(o_count), 32'd0);

      // Wrap-around stream with random gaps
      sent = 0; recv = 0; mcnt = 0; max_cnt = '0;
      for (int c = 0; c < 2000 && recv < 40; c++) begin
         drive(1'b0, (sent < 40) && ($urandom_range(0, 2) != 0), 8'(sent),
               $urandom_range(0, 2) != 0);
         wacc = i_wr_valid && o_wr_ready;
         racc = o_rd_valid && i_rd_ready;
         if (racc) begin
            chk("stream_data", 32'(o_rd_data), 32'(q.pop_front()));
            recv++;
            mcnt--;
         end
         if (wacc) begin
            q.push_back(sent);
            sent++;
            mcnt++;
         end
         cyc();
         chk("stream_count", 32'(o_count), 32'(mcnt));
         if (o_count > max_cnt) max_cnt = o_count;
      end
      chk("stream_recv", 32'(recv), 32'd40);
      chk("stream_max_le16", 32'(max_cnt <= 5'd16), 32'd1);
      drive(1'b0, 1'b0, 8'h00, 1'b0);

      // Flush with a concurrent write
      for (int i = 0; i < 7; i++) begin
         drive(1'b0, 1'b1, 8'(8'h70 + i), 1'b0);
         cyc();
      end
      chk("pre_clr_count", 32'(o_count), 32'd7);
      drive(1'b1, 1'b1, 8'hEE, 1'b0);
      cyc();
      chk("clr_count", 32'(o_count), 32'd0);
      chk("clr_rv", 32'(o_rd_valid), 32'd0);
      drive(1'b0, 1'b1, 8'h3C, 1'b0);
      cyc();
      chk("post_clr_head", 32'(o_rd_data), 32'h3C);

      // Refill to 9, then async reset between edges
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b1, 8'(8'h90 + i), 1'b0);
         cyc();
      end
      chk("pre_rst_count", 32'(o_count), 32'd9);
      drive(1'b0, 1'b1, 8'hBB, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_count", 32'(o_count), 32'd0);
      chk("arst_rv", 32'(o_rd_valid), 32'd0);
      chk("arst_wrdy", 32'(o_wr_ready), 32'd1);
      chk("arst_af", 32'(o_almost_full), 32'd0);
      chk("arst_rdata", 32'(o_rd_data), 32'd0);
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      cyc();
      rst = 1'b0;
      drive(1'b0, 1'b1, 8'h5A, 1'b0);
      cyc();
      chk("post_rst_rv", 32'(o_rd_valid), 32'd1);
      chk("post_rst_first", 32'(o_rd_data), 32'h5A);
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      cyc();
      chk("post_rst_empty", 32'(o_count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
